// File: rtl/bundling_add_cut_seq.sv
// ---------------------------------------------------------------------------
// bundling_add_cut_seq
//
// Sequential element-wise adder for hypervector bundling. It reads A[i] and
// B[i] over a single-port memory interface, then writes
// C[i] = f(A[i] + B[i]) for i = 0..D-1. f is latched per run and is a bipolar
// cut, a saturation to the element range, or a sign.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   valid / ready     start handshake (accepted on valid & ready)
//   mode              0 cut, 1 saturate, 2 sign, 3 same as 0
//   addr_a/b/c        base word addresses of A, B and C
//   raddress/data_rd  read port; element in data_rd[DATA_WIDTH-1:0]
//   we_n/waddress     active-low write strobe and write address
//   data_wr           result, sign-extended to 32 bits
//   done              one-cycle pulse after the last element is written
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready high, waiting for valid
// WAIT_A  | raddress holds A[i] address for RD_LATENCY cycles
// WAIT_B  | raddress holds B[i] address for RD_LATENCY cycles
// WRITE   | we_n low for one cycle with C[i] address and data
// ---------------------------------------------------------------------------
module bundling_add_cut_seq #(
    parameter int HYPERVECTOR_DIMENSIONS = 1000,
    parameter int DATA_WIDTH             = 8,
    parameter int RD_LATENCY             = 1,
    parameter int CUT_NEG                = -1,
    parameter int CUT_POS                = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [1:0]  mode,
    input  logic [20:0] addr_a,
    input  logic [20:0] addr_b,
    input  logic [20:0] addr_c,
    output logic        we_n,
    output logic [20:0] waddress,
    output logic [31:0] data_wr,
    output logic [20:0] raddress,
    input  logic [31:0] data_rd,
    output logic        done
);

    localparam int AW    = 21;
    localparam int IDX_W = (HYPERVECTOR_DIMENSIONS > 1) ? $clog2(HYPERVECTOR_DIMENSIONS) : 1;
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HYPERVECTOR_DIMENSIONS - 1);
    // Latency timer counts down from L-1; the transition happens on terminal count.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);
    localparam int SAT_HI = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int SAT_LO = -(1 << (DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_A,
        S_WAIT_B,
        S_WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [1:0]            mode_q, mode_d;
    logic [AW-1:0]         base_a_q, base_a_d;
    logic [AW-1:0]         base_b_q, base_b_d;
    logic [AW-1:0]         base_c_q, base_c_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic                  ready_q, ready_d;
    logic                  we_n_q, we_n_d;
    logic                  done_q, done_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [AW-1:0]         raddr_q, raddr_d;
    logic [31:0]           data_wr_q, data_wr_d;

    logic [AW-1:0]         idx_ext;
    logic signed [31:0]    op_a_ext;
    logic signed [31:0]    op_b_ext;
    logic signed [31:0]    sum;
    logic signed [31:0]    result;
    logic                  unused_rd_hi;

    assign idx_ext      = AW'(idx_q);
    assign op_a_ext     = {{(32-DATA_WIDTH){op_a_q[DATA_WIDTH-1]}}, op_a_q};
    assign op_b_ext     = {{(32-DATA_WIDTH){data_rd[DATA_WIDTH-1]}}, data_rd[DATA_WIDTH-1:0]};
    // Both operands fit in W bits, so the W+1-bit sum is exact in 32 bits.
    assign sum          = op_a_ext + op_b_ext;
    assign unused_rd_hi = ^data_rd[31:DATA_WIDTH];

    // Result stays within the W-bit range, so the 32-bit value is already
    // the sign extension of the W-bit result.
    always_comb begin
        result = sum;
        case (mode_q)
            2'd1: begin
                if (sum > SAT_HI)      result = SAT_HI;
                else if (sum < SAT_LO) result = SAT_LO;
            end
            2'd2: result = (sum < 0) ? -1 : 1;
            default: begin
                if (sum > CUT_POS)      result = CUT_POS;
                else if (sum < CUT_NEG) result = CUT_NEG;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        mode_d    = mode_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        base_c_d  = base_c_q;
        op_a_d    = op_a_q;
        ready_d   = ready_q;
        we_n_d    = we_n_q;
        done_d    = 1'b0;
        waddr_d   = waddr_q;
        raddr_d   = raddr_q;
        data_wr_d = data_wr_q;

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    mode_d   = mode;
                    base_a_d = addr_a;
                    base_b_d = addr_b;
                    base_c_d = addr_c;
                    idx_d    = '0;
                    raddr_d  = addr_a;
                    lat_d    = LAT_LOAD;
                    ready_d  = 1'b0;
                    state_d  = S_WAIT_A;
                end
            end
            S_WAIT_A: begin
                if (lat_q == '0) begin
                    op_a_d  = data_rd[DATA_WIDTH-1:0];
                    raddr_d = base_b_q + idx_ext;
                    lat_d   = LAT_LOAD;
                    state_d = S_WAIT_B;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_WAIT_B: begin
                if (lat_q == '0) begin
                    we_n_d    = 1'b0;
                    waddr_d   = base_c_q + idx_ext;
                    data_wr_d = result;
                    state_d   = S_WRITE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_WRITE: begin
                we_n_d = 1'b1;
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + IDX_W'(1);
                    raddr_d = base_a_q + idx_ext + AW'(1);
                    lat_d   = LAT_LOAD;
                    state_d = S_WAIT_A;
                end else begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lat_q     <= '0;
            mode_q    <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_c_q  <= '0;
            op_a_q    <= '0;
            ready_q   <= 1'b1;
            we_n_q    <= 1'b1;
            done_q    <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            data_wr_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            mode_q    <= mode_d;
            base_a_q  <= base_a_d;
            base_b_q  <= base_b_d;
            base_c_q  <= base_c_d;
            op_a_q    <= op_a_d;
            ready_q   <= ready_d;
            we_n_q    <= we_n_d;
            done_q    <= done_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            data_wr_q <= data_wr_d;
        end
    end

    assign ready    = ready_q;
    assign we_n     = we_n_q;
    assign done     = done_q;
    assign waddress = waddr_q;
    assign raddress = raddr_q;
    assign data_wr  = data_wr_q;

endmodule

// File: tb/tb_bundling_add_cut_seq.sv
// ---------------------------------------------------------------------------
// Bench for bundling_add_cut_seq. Two instances: unit 0 (D=4, L=1) and
// unit 1 (D=2, L=3), both W=8 with cut bounds [-1, 1]. A read-only word
// memory answers reads after the configured latency. Each run is checked
// cycle by cycle against the element schedule: per element, L cycles on
// A's address, L cycles on B's address, then one write cycle.
// ---------------------------------------------------------------------------
module tb_bundling_add_cut_seq;

    localparam int W  = 8;
    localparam int CN = -1;
    localparam int CP = 1;
    localparam int D0 = 4;
    localparam int L0 = 1;
    localparam int D1 = 2;
    localparam int L1 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid   [2];
    logic        ready   [2];
    logic [1:0]  mode    [2];
    logic [20:0] aa_in   [2];
    logic [20:0] ab_in   [2];
    logic [20:0] ac_in   [2];
    logic        we_n    [2];
    logic [20:0] waddress[2];
    logic [31:0] data_wr [2];
    logic [20:0] raddress[2];
    logic [31:0] data_rd [2];
    logic        done    [2];

    logic [20:0] hist[2][4];
    logic [31:0] mem [logic [20:0]];

    int checks = 0;
    int errors = 0;

    logic [1:0]  nx_md;
    logic [20:0] nx_a, nx_b, nx_c;

    bundling_add_cut_seq #(
        .HYPERVECTOR_DIMENSIONS(D0), .DATA_WIDTH(W), .RD_LATENCY(L0),
        .CUT_NEG(CN), .CUT_POS(CP)
    ) dut0 (
        .clk(clk), .reset(reset), .valid(valid[0]), .ready(ready[0]),
        .mode(mode[0]), .addr_a(aa_in[0]), .addr_b(ab_in[0]), .addr_c(ac_in[0]),
        .we_n(we_n[0]), .waddress(waddress[0]), .data_wr(data_wr[0]),
        .raddress(raddress[0]), .data_rd(data_rd[0]), .done(done[0])
    );

    bundling_add_cut_seq #(
        .HYPERVECTOR_DIMENSIONS(D1), .DATA_WIDTH(W), .RD_LATENCY(L1),
        .CUT_NEG(CN), .CUT_POS(CP)
    ) dut1 (
        .clk(clk), .reset(reset), .valid(valid[1]), .ready(ready[1]),
        .mode(mode[1]), .addr_a(aa_in[1]), .addr_b(ab_in[1]), .addr_c(ac_in[1]),
        .we_n(we_n[1]), .waddress(waddress[1]), .data_wr(data_wr[1]),
        .raddress(raddress[1]), .data_rd(data_rd[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    function automatic int dim_of(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? L0 : L1;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [20:0] a);
        if (mem.exists(a)) return mem[a];
        return {11'h5A5, a};
    endfunction

    function automatic int elem(input logic [31:0] v);
        logic [7:0] b;
        b = v[7:0];
        return int'($signed(b));
    endfunction

    // Post-operation from the mode rules, in plain integer arithmetic.
    function automatic int post(input int s, input int md);
        int lo, hi;
        if (md == 2) return (s >= 0) ? 1 : -1;
        if (md == 1) begin
            lo = -(1 << (W - 1));
            hi = (1 << (W - 1)) - 1;
        end else begin
            lo = CN;
            hi = CP;
        end
        if (s < lo) return lo;
        if (s > hi) return hi;
        return s;
    endfunction

    // Memory answers the address that was presented L-1 cycles earlier.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (lat_of(u) == 1) data_rd[u] <= mem_rd(raddress[u]);
            else                data_rd[u] <= mem_rd(hist[u][lat_of(u) - 2]);
            hist[u][0] <= raddress[u];
            for (int j = 3; j > 0; j--) hist[u][j] <= hist[u][j - 1];
        end
    end

    task automatic put(input logic [20:0] ad, input int v);
        logic [31:0] w;
        w = $urandom();
        w[7:0] = v[7:0];
        mem[ad] = w;
    endtask

    task automatic run(input int u, input int md, input logic [20:0] a, input logic [20:0] b,
                       input logic [20:0] c, input int glitch_k, input bit chain,
                       input bit prestarted, input string name);
        int d, l, p, i, ph;
        logic [20:0] exp_a[$];
        logic [31:0] exp_d[$];
        logic [20:0] ra_exp, last_wa;
        logic [31:0] last_wd;
        logic exp_we, exp_end;
        bit wr, written;
        d = dim_of(u);
        l = lat_of(u);
        p = 2 * l + 1;
        written = 0;
        last_wa = '0;
        last_wd = '0;
        for (int e = 0; e < d; e++) begin
            exp_a.push_back(c + 21'(e));
            exp_d.push_back(32'(post(elem(mem_rd(a + 21'(e))) + elem(mem_rd(b + 21'(e))), md)));
        end
        if (!prestarted) begin
            @(negedge clk);
            valid[u] = 1'b1;
            mode[u]  = 2'(md);
            aa_in[u] = a;
            ab_in[u] = b;
            ac_in[u] = c;
        end
        for (int k = 0; k <= d * p; k++) begin
            @(negedge clk);
            if (k == 0) begin
                valid[u] = 1'b0;
                mode[u]  = 2'($urandom);
                aa_in[u] = 21'($urandom);
                ab_in[u] = 21'($urandom);
                ac_in[u] = 21'($urandom);
            end
            if (k == glitch_k) begin
                valid[u] = 1'b1;
                mode[u]  = 2'($urandom);
                aa_in[u] = 21'($urandom);
                ab_in[u] = 21'($urandom);
                ac_in[u] = 21'($urandom);
            end
            if (k == glitch_k + 1) valid[u] = 1'b0;
            if (chain && k == d * p - 1) begin
                valid[u] = 1'b1;
                mode[u]  = nx_md;
                aa_in[u] = nx_a;
                ab_in[u] = nx_b;
                ac_in[u] = nx_c;
            end
            i  = k / p;
            ph = k % p;
            wr = (k < d * p) && (ph == 2 * l);
            exp_we  = wr ? 1'b0 : 1'b1;
            exp_end = (k == d * p) ? 1'b1 : 1'b0;
            if (k == d * p)  ra_exp = b + 21'(d - 1);
            else if (ph < l) ra_exp = a + 21'(i);
            else             ra_exp = b + 21'(i);
            checks++;
            if (raddress[u] !== ra_exp) begin
                errors++;
                $display("FAIL %s raddress u%0d k%0d got %h want %h", name, u, k, raddress[u], ra_exp);
            end
            checks++;
            if (we_n[u] !== exp_we) begin
                errors++;
                $display("FAIL %s we_n u%0d k%0d got %b want %b", name, u, k, we_n[u], exp_we);
            end
            checks++;
            if (done[u] !== exp_end) begin
                errors++;
                $display("FAIL %s done u%0d k%0d got %b want %b", name, u, k, done[u], exp_end);
            end
            checks++;
            if (ready[u] !== exp_end) begin
                errors++;
                $display("FAIL %s ready u%0d k%0d got %b want %b", name, u, k, ready[u], exp_end);
            end
            if (wr) begin
                last_wa = exp_a[i];
                last_wd = exp_d[i];
                written = 1;
            end
            if (written) begin
                checks++;
                if (waddress[u] !== last_wa) begin
                    errors++;
                    $display("FAIL %s waddress u%0d k%0d got %h want %h", name, u, k, waddress[u], last_wa);
                end
                checks++;
                if (data_wr[u] !== last_wd) begin
                    errors++;
                    $display("FAIL %s data_wr u%0d k%0d got %h want %h", name, u, k, data_wr[u], last_wd);
                end
            end
        end
    endtask

    task automatic check_idle(input int u, input string name);
        checks++;
        if (ready[u] !== 1'b1 || we_n[u] !== 1'b1 || done[u] !== 1'b0) begin
            errors++;
            $display("FAIL %s u%0d ready/we_n/done got %b%b%b want 110", name, u, ready[u], we_n[u], done[u]);
        end
    endtask

    task automatic check_zero(input int u, input string name);
        checks++;
        if (raddress[u] !== 21'd0 || waddress[u] !== 21'd0 || data_wr[u] !== 32'd0) begin
            errors++;
            $display("FAIL %s u%0d raddr/waddr/data got %h %h %h want zeros", name, u,
                     raddress[u], waddress[u], data_wr[u]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_idle(u, "reset_in");
            check_zero(u, "reset_in");
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_idle(u, "reset_out");
            check_zero(u, "reset_out");
        end
    endtask

    task automatic dir4(input int md, input int av[4], input int bv[4], input logic [20:0] c,
                        input string name);
        logic [20:0] a, b;
        a = 21'h000010 + 21'($urandom_range(0, 255));
        b = 21'h000400 + 21'($urandom_range(0, 255));
        for (int e = 0; e < 4; e++) begin
            put(a + 21'(e), av[e]);
            put(b + 21'(e), bv[e]);
        end
        run(0, md, a, b, c, -1, 0, 0, name);
    endtask

    task automatic test_cut();
        int av[4], bv[4];
        av = '{1, -1, 1, 0};
        bv = '{1, -1, -1, 0};
        dir4(0, av, bv, 21'h000100, "cut_mode0");
    endtask

    task automatic test_saturate();
        int av[4], bv[4];
        av = '{100, -100, 5, 127};
        bv = '{100, -100, -3, 0};
        dir4(1, av, bv, 21'h000200, "saturate");
    endtask

    task automatic test_sign();
        int av[4], bv[4];
        av = '{0, -2, 3, 1};
        bv = '{0, -1, -3, 0};
        dir4(2, av, bv, 21'h000300, "sign");
    endtask

    task automatic test_wrap_l3();
        put(21'h1FFFFF, 90);
        put(21'h000000, -7);
        put(21'h000800, 50);
        put(21'h000801, -4);
        run(1, 1, 21'h1FFFFF, 21'h000800, 21'h1FFFFF, -1, 0, 0, "wrap_l3");
    endtask

    task automatic fill_random(input int u, input logic [20:0] a, input logic [20:0] b);
        for (int e = 0; e < dim_of(u); e++) begin
            mem[a + 21'(e)] = $urandom();
            mem[b + 21'(e)] = $urandom();
        end
    endtask

    task automatic test_busy_glitch();
        fill_random(0, 21'h000500, 21'h000600);
        run(0, 1, 21'h000500, 21'h000600, 21'h000700, 3, 0, 0, "busy_glitch");
        fill_random(1, 21'h000510, 21'h000610);
        run(1, 0, 21'h000510, 21'h000610, 21'h000710, 5, 0, 0, "busy_glitch_l3");
    endtask

    task automatic test_back_to_back();
        fill_random(0, 21'h000900, 21'h000A00);
        fill_random(0, 21'h000B00, 21'h000C00);
        nx_md = 2'd2;
        nx_a  = 21'h000B00;
        nx_b  = 21'h000C00;
        nx_c  = 21'h000D00;
        run(0, 0, 21'h000900, 21'h000A00, 21'h000E00, -1, 1, 0, "b2b_first");
        run(0, 2, nx_a, nx_b, nx_c, -1, 0, 1, "b2b_second");
    endtask

    task automatic test_reset_mid_run();
        fill_random(0, 21'h001000, 21'h001100);
        @(negedge clk);
        valid[0] = 1'b1;
        mode[0]  = 2'd1;
        aa_in[0] = 21'h001000;
        ab_in[0] = 21'h001100;
        ac_in[0] = 21'h001200;
        for (int k = 0; k <= 3 + 2 * L0; k++) begin
            @(negedge clk);
            if (k == 0) valid[0] = 1'b0;
        end
        checks++;
        if (we_n[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid we_n before reset got %b want 0", we_n[0]);
        end
        #2 reset = 1'b1;
        #1;
        check_idle(0, "rst_mid_async");
        check_zero(0, "rst_mid_async");
        repeat (2) begin
            @(negedge clk);
            check_idle(0, "rst_mid_held");
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle(0, "rst_mid_after");
        end
        fill_random(0, 21'h001300, 21'h001400);
        run(0, 1, 21'h001300, 21'h001400, 21'h001500, -1, 0, 0, "rst_mid_fresh");
    endtask

    task automatic test_random();
        logic [20:0] a, b, c;
        int md;
        for (int n = 0; n < 8; n++) begin
            for (int u = 0; u < 2; u++) begin
                a  = 21'($urandom);
                b  = 21'($urandom);
                c  = 21'($urandom);
                md = $urandom_range(0, 3);
                fill_random(u, a, b);
                run(u, md, a, b, c, -1, 0, 0, "random");
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            valid[u] = 1'b0;
            mode[u]  = 2'd0;
            aa_in[u] = '0;
            ab_in[u] = '0;
            ac_in[u] = '0;
        end
        test_reset();
        test_cut();
        test_saturate();
        test_sign();
        test_wrap_l3();
        test_busy_glitch();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bundling_add_cut_seq.md
# bundling_add_cut_seq

Parametrised sequential element-wise adder for bundling hypervectors. It walks two stored hypervectors A and B element by element over the shared single-port memory interface, then writes C[i] = f(A[i] + B[i]) to a third region. f is a run-time-selected post-operation: bipolar cut, saturation or sign. It sits in the bundling stage beside the other element-addition kernels and replaces the fixed single-element cut adder with a full-vector, configurable-latency, multi-mode engine.

## Interface
- HYPERVECTOR_DIMENSIONS, 1000, elements per vector (D); must be ≥1
- DATA_WIDTH, 8, signed element width W held in data_rd[W-1:0]; 2..31
- RD_LATENCY, 1, memory read latency L in cycles; must be ≥1
- CUT_NEG, -1, lower clip bound for mode 0; must satisfy CUT_NEG ≤ CUT_POS
- CUT_POS, 1, upper clip bound for mode 0
- clk  in  1  the only clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- valid  in  1  start request; sampled only while ready=1
- ready  out  1  high in IDLE; the block accepts a start on valid&ready
- mode  in  2  0=cut, 1=saturate, 2=sign, 3=reserved (behaves as 0); latched at accept
- addr_a  in  21  base word address of A; latched at accept
- addr_b  in  21  base word address of B; latched at accept
- addr_c  in  21  base word address of result C; latched at accept
- we_n  out  1  active-low write strobe
- waddress  out  21  write address
- data_wr  out  32  write data, result sign-extended from W bits
- raddress  out  21  read address
- data_rd  in  32  read data; bits [W-1:0] are the signed element, upper bits ignored
- done  out  1  one-cycle pulse when the last element is written

## Operation
- States: IDLE, WAIT_A, WAIT_B, WRITE. Element index i runs 0..D-1; its counter is $clog2(D) bits, minimum 1.
- IDLE: ready=1. When valid is sampled high:
  - latch mode, addr_a, addr_b and addr_c;
  - clear i and set raddress<=addr_a;
  - ready<=0 and go to WAIT_A.
- WAIT_A: hold raddress for L cycles. On the L-th edge, capture op_a<=data_rd[W-1:0], set raddress<=addr_b+i and go to WAIT_B.
- WAIT_B: hold for L cycles. On the L-th edge:
  - compute s = op_a + data_rd[W-1:0] in W+1 signed bits;
  - register we_n<=0, waddress<=addr_c+i and data_wr<=sext(f(s));
  - go to WRITE.
- WRITE: the write strobe is visible for exactly this cycle. On the next edge, we_n<=1, then:
  - if i<D-1: increment i, set raddress<=addr_a+i+1 and go to WAIT_A;
  - otherwise: done<=1, ready<=1 and go to IDLE.
- f by mode:
  - 0: clip s to [CUT_NEG, CUT_POS];
  - 1: clip s to [-2^(W-1), 2^(W-1)-1];
  - 2: +1 if s≥0, else -1 (a zero sum breaks the tie to +1).
- Address arithmetic is modulo 2^21. Base+i wraps past 0x1FFFFF to 0x000000.
- valid, mode and addresses are ignored while ready=0. Inputs changing mid-run have no effect.
- waddress and data_wr hold their last values when we_n=1. raddress holds its last value in IDLE.
- reset, asynchronous and at any time, immediately forces state IDLE and:
  - we_n=1, waddress=0, data_wr=0, raddress=0;
  - done=0, ready=1, i=0.
  - An in-flight write strobe is cancelled and no partial-vector completion is signalled.

## Timing
- Reset values: ready=1, we_n=1, waddress=0, data_wr=0, raddress=0, done=0.
- Take accept edge as edge 0. Element i's write strobe is low during cycle (i+1)(2L+1)-1 to (i+1)(2L+1).
- done is high for the single cycle following the last WRITE cycle. That is D(2L+1) cycles after the accept edge: 12 cycles for D=4, L=1.
- ready rises together with done. valid held high through that cycle starts the next run on the following edge, so back-to-back runs need no idle gap.
- Exactly D writes per run, in ascending i order, and no write outside WRITE.
- raddress is stable for the full L cycles of each WAIT state.

## Test plan
- Mode-0 cut, D=4, L=1, W=8:
  - stimulus: A=[1,-1,1,0], B=[1,-1,-1,0], addr_c=0x100;
  - response: writes 0x100..0x103 = [1, -1, 0, 0], with data_wr 0xFFFFFFFF for -1;
  - done pulses 12 cycles after accept, and ready=0 throughout the run.
- Mode 1, W=8:
  - stimulus: pairs (100,100), (-100,-100), (5,-3), (127,0);
  - response: results 127, -128 (data_wr=0xFFFFFF80), 2, 127.
- Mode 2:
  - stimulus: pairs (0,0), (-2,-1), (3,-3), (1,0);
  - response: results +1, -1, +1, +1.
- L=3 and address wrap:
  - stimulus: D=2, addr_a=0x1FFFFF, addr_c=0x1FFFFF;
  - response: raddress steps 0x1FFFFF→addr_b→0x000000;
  - writes land at 0x1FFFFF then 0x000000, each element takes 7 cycles, and done arrives 14 cycles after accept.
- Handshake:
  - valid pulsed while busy: ignored, with no change to the latched addresses or mode;
  - valid held high across done: the second run is accepted on the edge after done, and mode 2 is latched at that second accept.
- Reset during the WRITE cycle of element 1:
  - response: we_n rises before the next clock edge and no further writes occur;
  - done is never asserted, ready=1 immediately, and a fresh run after release completes normally.
